// File: rtl/oled_pkg.sv
// Shared constants, state encoding and request validation for the OLED character scheduler.
package oled_pkg;

  localparam int unsigned FONT12    = 12;
  localparam int unsigned FONT16    = 16;
  localparam int unsigned FONT24    = 24;
  localparam int unsigned ASCII_MIN = 33;
  localparam int unsigned ASCII_MAX = 126;
  localparam int unsigned X_W       = 7;
  localparam int unsigned Y_W       = 6;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StLaunch,
    StWaitDone,
    StRefresh
  } state_e;

  // Renderable glyph: printable ASCII in one of the three supported font sizes.
  function automatic logic char_ok(input logic [7:0] ascii, input logic [4:0] font);
    return ((font == 5'(FONT12)) || (font == 5'(FONT16)) || (font == 5'(FONT24))) &&
           (ascii >= 8'(ASCII_MIN)) && (ascii <= 8'(ASCII_MAX));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set bit of valid at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] winner,
  output logic             any
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  int unsigned       off;
  int unsigned       sum;

  always_comb begin
    // Rotate so the search always starts at bit 0.
    dbl = {valid, valid} >> ptr;
    rot = dbl[NREQ-1:0];
    off = 0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        off = k;
      end
    end
    sum = 32'(ptr) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    winner = PTR_W'(sum);
    grant  = any ? (NREQ'(1) << winner) : '0;
  end

endmodule

// File: rtl/oled_char_scheduler.sv
// Shares one OLED character renderer among NREQ requesters: arbitrate, validate, launch,
// wait for completion, then hand the frame RAM to the refresh driver.
module oled_char_scheduler
  import oled_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned PTR_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_ascii,
  input  logic [NREQ*5-1:0] req_font,
  input  logic [NREQ*7-1:0] req_x,
  input  logic [NREQ*6-1:0] req_y,
  output logic [NREQ-1:0]   req_ready,
  output logic              char_en,
  output logic [7:0]        char_ascii,
  output logic [4:0]        char_font,
  output logic [X_W-1:0]    char_x,
  output logic [Y_W-1:0]    char_y,
  input  logic              char_done,
  output logic              refresh_req,
  input  logic              refresh_ack,
  output logic              busy,
  output logic              err_timeout,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT) + 1;

  state_e             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [TMR_W-1:0]   timer;
  logic               grant_ok;

  logic [NREQ-1:0]    grant;
  logic [PTR_W-1:0]   winner;
  logic               any;

  logic [7:0]         sel_ascii;
  logic [4:0]         sel_font;
  logic [X_W-1:0]     sel_x;
  logic [Y_W-1:0]     sel_y;
  logic               sel_ok;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .valid  (req_valid),
    .ptr    (rr_ptr),
    .grant  (grant),
    .winner (winner),
    .any    (any)
  );

  // One-hot AND-OR mux of the winning requester's fields.
  always_comb begin
    sel_ascii = '0;
    sel_font  = '0;
    sel_x     = '0;
    sel_y     = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_ascii = sel_ascii | (req_ascii[8*i +: 8] & {8{grant[i]}});
      sel_font  = sel_font  | (req_font[5*i +: 5]  & {5{grant[i]}});
      sel_x     = sel_x     | (req_x[7*i +: 7]     & {7{grant[i]}});
      sel_y     = sel_y     | (req_y[6*i +: 6]     & {6{grant[i]}});
    end
    sel_ok = char_ok(sel_ascii, sel_font);
  end

  assign busy = (state != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      rr_ptr      <= '0;
      timer       <= '0;
      grant_ok    <= 1'b0;
      req_ready   <= '0;
      char_en     <= 1'b0;
      char_ascii  <= '0;
      char_font   <= '0;
      char_x      <= '0;
      char_y      <= '0;
      refresh_req <= 1'b0;
      err_timeout <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      req_ready <= '0;
      char_en   <= 1'b0;
      unique case (state)
        StIdle: begin
          // Arbitrate here so req_ready and char_* are already registered during GRANT.
          if (any) begin
            state     <= StGrant;
            req_ready <= grant;
            rr_ptr    <= (winner == PTR_W'(NREQ - 1)) ? '0 : winner + PTR_W'(1);
            grant_ok  <= sel_ok;
            if (sel_ok) begin
              char_ascii <= sel_ascii;
              char_font  <= sel_font;
              char_x     <= sel_x;
              char_y     <= sel_y;
            end
          end
        end
        StGrant: begin
          if (grant_ok) begin
            state   <= StLaunch;
            char_en <= 1'b1;
            timer   <= '0;
          end else begin
            state <= StIdle;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          end
        end
        StLaunch: begin
          // The launch cycle counts toward the renderer budget.
          timer <= timer + TMR_W'(1);
          state <= StWaitDone;
        end
        StWaitDone: begin
          if (char_done) begin
            state       <= StRefresh;
            refresh_req <= 1'b1;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            state       <= StIdle;
            err_timeout <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        StRefresh: begin
          if (refresh_ack) begin
            state       <= StIdle;
            refresh_req <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/oled_char_scheduler.md
Name: oled_char_scheduler

Overview:
- Shares the single OLED character renderer among NREQ requesters, e.g. a status text source, a key-driven cursor and a debug readout.
- Arbitrates among requesters with round-robin priority and validates each request.
- Launches the renderer with a one-cycle enable, then waits for its completion pulse.
- Hands the finished frame RAM to the panel refresh driver through a req/ack handshake before serving the next request.
- Sits between the requester logic and the renderer / SPI refresh path.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 4096, cycles allowed between char_en and char_done before abort
PTR_W, 2, width of the round-robin pointer; must be at least clog2(NREQ)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  NREQ  per-requester request; held until accepted
req_ascii  in  NREQ*8  ASCII code per requester; slice i is bits [8i+7:8i]
req_font  in  NREQ*5  font size per requester (12, 16 or 24)
req_x  in  NREQ*7  x coordinate 0..127 per requester
req_y  in  NREQ*6  y coordinate 0..63 per requester
req_ready  out  NREQ  one-hot, one-cycle accept pulse
char_en  out  1  one-cycle start pulse to the renderer
char_ascii  out  8  latched ASCII code
char_font  out  5  latched font size
char_x  out  7  latched x coordinate
char_y  out  6  latched y coordinate
char_done  in  1  renderer completion pulse (frame RAM fully written)
refresh_req  out  1  level request to the panel refresh driver
refresh_ack  in  1  refresh driver acknowledge
busy  out  1  high in every state except IDLE
err_timeout  out  1  sticky; set on renderer timeout
drop_cnt  out  8  saturating count of rejected requests

Behaviour:
- Reset (async, rst=1): every output is 0; state=IDLE; rr_ptr=0; timer=0; err_timeout=0; drop_cnt=0. Reset asserted mid-operation abandons the operation at once; the renderer is not re-kicked.
- Arbitration:
  - Search starts at index rr_ptr and wraps modulo NREQ.
  - The first i with req_valid[i]=1 wins.
  - After a grant, rr_ptr = (winner+1) mod NREQ.
- FSM states: IDLE, GRANT, LAUNCH, WAIT_DONE, REFRESH.
  - IDLE: if any req_valid is set, go to GRANT; otherwise stay.
  - GRANT:
    - req_ready[winner] pulses for exactly this cycle.
    - The winner's fields are latched into char_*.
    - The request is invalid if font is not in {12,16,24}, or ascii is <33 or >126.
    - Invalid request: increment drop_cnt (saturates at 255) and go to IDLE. char_* keep their previous values.
    - Valid request: go to LAUNCH.
  - LAUNCH: char_en=1 for this cycle only; timer=0; go to WAIT_DONE.
  - WAIT_DONE:
    - timer increments each cycle.
    - char_done=1: go to REFRESH.
    - Otherwise, timer==TIMEOUT-1: set err_timeout and go to IDLE, with no refresh.
    - char_done and timeout in the same cycle: done wins.
  - REFRESH:
    - refresh_req=1 is held high until a cycle with refresh_ack=1.
    - On that cycle refresh_req drops on the next edge and the FSM goes to IDLE.
    - No timeout applies in REFRESH.
- Latency:
  - req_valid rising in IDLE gives req_ready at +1 cycle and char_en at +2 cycles.
  - Minimum request-to-next-GRANT time is 5 cycles (GRANT, LAUNCH, WAIT_DONE≥1, REFRESH≥1, IDLE).
- char_done outside WAIT_DONE is ignored. refresh_ack outside REFRESH is ignored.
- char_* outputs stay stable from GRANT until the next GRANT of a valid request.
- err_timeout clears only on reset.
- req_valid dropped by a requester before its grant is legal; that requester is simply not considered.

Decomposition:
- Shared package oled_pkg holds:
  - font size constants FONT12=12, FONT16=16, FONT24=24;
  - ASCII_MIN=33, ASCII_MAX=126;
  - the state encoding enum;
  - coordinate widths X_W=7, Y_W=6.
- One sub-module is natural: rr_arbiter, a parameterized NREQ round-robin picker.
  - Inputs: valid, ptr.
  - Outputs: one-hot grant, winner index, any.

Test Plan:
- Single valid request: req_valid[0]=1, ascii=0x41, font=16, x=10, y=8. Required: req_ready[0] at +1 cycle; char_en at +2 with char_x=10, char_y=8; char_done 20 cycles later; refresh_req high until refresh_ack; then busy=0.
- Round-robin fairness: req_valid=4'b1111 held through 8 transactions. Grant order must be 0,1,2,3,0,1,2,3, with exactly one req_ready bit per GRANT.
- Invalid font: font=20, or ascii=0x20. Required: req_ready pulses, no char_en, drop_cnt goes 0→1, FSM back in IDLE. 300 invalid requests leave drop_cnt=255.
- Timeout: TIMEOUT=16 and char_done never arrives. Required: err_timeout=1 exactly 16 cycles after char_en; no refresh_req; the next request is still served.
- Simultaneous events: char_done on the same cycle as timer==TIMEOUT-1 must go to REFRESH with err_timeout staying 0. A stray char_done in IDLE must be ignored.
- Reset mid-operation: assert rst while in WAIT_DONE and while in REFRESH with refresh_req=1. All outputs must go to 0 asynchronously, and after release the first grant goes to index 0.
